// File: rtl/magnetron_pkg.sv
// Shared state encoding and power-level helpers for the magnetron controller.
package magnetron_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DUTY_SLOTS = 10;
    localparam int MAX_POWER  = 10;

    // Keypad values above full power are treated as full power.
    function automatic logic [3:0] sat_power(input logic [3:0] lvl);
        return (lvl > 4'(MAX_POWER)) ? 4'(MAX_POWER) : lvl;
    endfunction

endpackage

// File: rtl/magnetron_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The count is held while disabled so a paused cook resumes mid-second.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Tick is independent of clr so the controller can derive clr from its next-state logic.
    assign tick = en & (count == LAST);

endmodule

// File: rtl/magnetron_ctrl.sv
// Magnetron sequencer: cook countdown, door interlock, power duty cycling.
// Optional done beep is built when DONE_BEEP_EN is defined.
//
// state | meaning
// IDLE  | waiting for start with door shut and non-zero time
// COOK  | counting down, magnetron duty-cycled by power level
// PAUSE | countdown, duty slot and prescaler frozen
// DONE  | countdown expired, waiting for acknowledge
module magnetron_ctrl
    import magnetron_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int TIME_W    = 13
`ifdef DONE_BEEP_EN
    ,
    parameter int BEEP_SECS = 3
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop_clear,
    input  logic              door_closed,
    input  logic [TIME_W-1:0] time_load,
    input  logic [3:0]        power_lvl,
    output logic              magnetron_on,
    output logic              cooking,
    output logic              done,
    output logic [TIME_W-1:0] time_left
`ifdef DONE_BEEP_EN
    ,
    output logic              beep
`endif
);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [TIME_W-1:0] time_nx;
    logic [3:0]        duty;
    logic [3:0]        duty_nx;
    logic [3:0]        pwr;
    logic              mag_q;
    logic              door_q;
    logic              tick;
    logic              pre_en;
    logic              pre_clr;

    assign pwr = sat_power(power_lvl);

    // Prescaler runs only in an uninterrupted COOK cycle, so a pause freezes it mid-second.
`ifdef DONE_BEEP_EN
    assign pre_en = ((state == ST_COOK) & door_closed & ~stop_clear) | (state == ST_DONE);
`else
    assign pre_en = (state == ST_COOK) & door_closed & ~stop_clear;
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (tick)
    );

    always_comb begin
        state_nx = state;
        time_nx  = time_left;
        duty_nx  = duty;
        pre_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!stop_clear && start && door_closed && (time_load != '0)) begin
                    state_nx = ST_COOK;
                    time_nx  = time_load;
                    duty_nx  = 4'd0;
                    pre_clr  = 1'b1;
                end
            end
            ST_COOK: begin
                if (stop_clear || !door_closed) begin
                    state_nx = ST_PAUSE;
                end else if (tick) begin
                    duty_nx = (duty == 4'(DUTY_SLOTS - 1)) ? 4'd0 : duty + 4'd1;
                    if (time_left <= TIME_W'(1)) begin
                        state_nx = ST_DONE;
                        time_nx  = '0;
                    end else begin
                        time_nx = time_left - 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    state_nx = ST_IDLE;
                    time_nx  = '0;
                end else if (start && door_closed) begin
                    state_nx = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_clear || start || (door_q && !door_closed)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                time_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            time_left <= '0;
            duty      <= 4'd0;
            mag_q     <= 1'b0;
            cooking   <= 1'b0;
            done      <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            time_left <= time_nx;
            duty      <= duty_nx;
            mag_q     <= (state_nx == ST_COOK) && (duty_nx < pwr);
            cooking   <= (state_nx == ST_COOK);
            done      <= (state_nx == ST_DONE);
            door_q    <= door_closed;
        end
    end

    // Door term bypasses the register so an opened door kills the drive in the same cycle.
    assign magnetron_on = mag_q & door_closed;

`ifdef DONE_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_SECS + 1);

    logic [BEEP_W-1:0] beep_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt <= '0;
            beep     <= 1'b0;
        end else if ((state != ST_DONE) && (state_nx == ST_DONE)) begin
            beep_cnt <= BEEP_W'(BEEP_SECS);
            beep     <= (BEEP_SECS != 0);
        end else if (state_nx != ST_DONE) begin
            beep_cnt <= '0;
            beep     <= 1'b0;
        end else if (tick && (beep_cnt != '0)) begin
            beep_cnt <= beep_cnt - 1'b1;
            if (beep_cnt == BEEP_W'(1)) begin
                beep <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Self-checking bench for magnetron_ctrl with a 4-cycle second.
// Expected observations are queued per cycle and popped as the DUT is sampled.
module tb_magnetron_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TIME_W   = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              stop_clear = 1'b0;
    logic              door_closed = 1'b0;
    logic [TIME_W-1:0] time_load = '0;
    logic [3:0]        power_lvl = 4'd0;
    logic              magnetron_on;
    logic              cooking;
    logic              done;
    logic [TIME_W-1:0] time_left;
`ifdef DONE_BEEP_EN
    logic              beep;
`endif

    typedef struct packed {
        logic              mag;
        logic              cook;
        logic              dn;
        logic [TIME_W-1:0] tl;
    } obs_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    magnetron_ctrl #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop_clear   (stop_clear),
        .door_closed  (door_closed),
        .time_load    (time_load),
        .power_lvl    (power_lvl),
        .magnetron_on (magnetron_on),
        .cooking      (cooking),
        .done         (done),
        .time_left    (time_left)
`ifdef DONE_BEEP_EN
        ,
        .beep         (beep)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        obs_t e;
        obs_t got;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(obs_t'('0));
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset i=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_cook_basic();
        obs_t e;
        obs_t got;
        door_closed = 1'b1; power_lvl = 4'd10; time_load = TIME_W'(3);
        for (int c = 0; c < 16; c++) begin
            e.mag  = (c < 12);
            e.cook = (c < 12);
            e.dn   = (c >= 12);
            e.tl   = (c < 12) ? TIME_W'(3 - c / 4) : '0;
            sb.push_back(e);
        end
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL cook_basic c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
        end
        // Door opening while DONE acknowledges it.
        @(posedge clk); #1 door_closed = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || cooking !== 1'b0) begin
            n_fail++;
            $display("FAIL done_door_exit got done=%b cooking=%b want 0/0", done, cooking);
        end
        door_closed = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_duty();
        obs_t e;
        obs_t got;
        door_closed = 1'b1; power_lvl = 4'd5; time_load = TIME_W'(20);
        for (int c = 0; c <= 80; c++) begin
            e.mag  = (c < 80) && (((c / 4) % 10) < 5);
            e.cook = (c < 80);
            e.dn   = (c >= 80);
            e.tl   = (c < 80) ? TIME_W'(20 - c / 4) : '0;
            sb.push_back(e);
        end
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c <= 80; c++) begin
            @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL duty5 c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
        end
        @(posedge clk); #1 stop_clear = 1'b1;
        @(posedge clk); #1 stop_clear = 1'b0;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clear got done=%b want 0", done);
        end
        // Power 0: countdown runs, drive never asserted.
        power_lvl = 4'd0; time_load = TIME_W'(2);
        for (int c = 0; c <= 8; c++) begin
            e.mag  = 1'b0;
            e.cook = (c < 8);
            e.dn   = (c >= 8);
            e.tl   = (c < 8) ? TIME_W'(2 - c / 4) : '0;
            sb.push_back(e);
        end
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL duty0 c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || cooking !== 1'b0) begin
            n_fail++;
            $display("FAIL done_start_exit got done=%b cooking=%b want 0/0", done, cooking);
        end
    endtask

    task automatic test_door();
        obs_t e;
        obs_t got;
        door_closed = 1'b1; power_lvl = 4'd10; time_load = TIME_W'(5);
        for (int c = 0; c < 6; c++) sb.push_back({1'b1, 1'b1, 1'b0, TIME_W'(5 - c / 4)});
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL door_pre c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
        end
        #1 door_closed = 1'b0;
        #1;
        n_checks++;
        if (magnetron_on !== 1'b0) begin
            n_fail++;
            $display("FAIL door_interlock got magnetron_on=%b want 0", magnetron_on);
        end
        for (int c = 0; c < 3; c++) sb.push_back({1'b0, 1'b0, 1'b0, TIME_W'(4)});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL door_pause c=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
        end
        // Prescaler was at 1 when paused: first tick arrives 3 cycles after resume.
        for (int r = 0; r < 5; r++) sb.push_back({1'b1, 1'b1, 1'b0, TIME_W'((r < 3) ? 4 : 3)});
        @(posedge clk); #1 door_closed = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL door_resume r=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", r,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
        end
        @(posedge clk); #1 stop_clear = 1'b1;
        @(posedge clk); @(posedge clk); #1 stop_clear = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stop();
        obs_t e;
        obs_t got;
        door_closed = 1'b1; power_lvl = 4'd10; time_load = TIME_W'(6);
        sb.push_back({1'b0, 1'b0, 1'b0, TIME_W'(0)});
        sb.push_back({1'b1, 1'b1, 1'b0, TIME_W'(6)});
        sb.push_back({1'b0, 1'b0, 1'b0, TIME_W'(6)});
        sb.push_back({1'b0, 1'b0, 1'b0, TIME_W'(6)});
        sb.push_back({1'b0, 1'b0, 1'b0, TIME_W'(0)});
        for (int s = 0; s < 5; s++) begin
            case (s)
                1: begin start = 1'b1; @(posedge clk); #1 start = 1'b0; end
                2: begin stop_clear = 1'b1; @(posedge clk); #1 stop_clear = 1'b0; end
                4: begin stop_clear = 1'b1; @(posedge clk); #1 stop_clear = 1'b0; end
                default: begin @(posedge clk); #1; end
            endcase
            @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL stop s=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", s,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
            @(posedge clk); #1;
        end
        // start together with stop_clear: stop wins in COOK (pause) and in PAUSE (clear).
        sb.push_back({1'b1, 1'b1, 1'b0, TIME_W'(6)});
        sb.push_back({1'b0, 1'b0, 1'b0, TIME_W'(6)});
        sb.push_back({1'b0, 1'b0, 1'b0, TIME_W'(0)});
        for (int s = 0; s < 3; s++) begin
            start = 1'b1; stop_clear = (s > 0);
            @(posedge clk); #1 start = 1'b0; stop_clear = 1'b0;
            @(negedge clk);
            e   = sb.pop_front();
            got = {magnetron_on, cooking, done, time_left};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL start_stop s=%0d got %b/%b/%b/%0d want %b/%b/%b/%0d", s,
                         got.mag, got.cook, got.dn, got.tl, e.mag, e.cook, e.dn, e.tl);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore();
        obs_t e;
        obs_t got;
        power_lvl = 4'd10;
        for (int s = 0; s < 3; s++) begin
            time_load   = (s == 0) ? TIME_W'(0) : TIME_W'(7);
            door_closed = (s != 1);
            if (s < 2) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            for (int c = 0; c < 3; c++) sb.push_back(obs_t'('0));
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                e   = sb.pop_front();
                got = {magnetron_on, cooking, done, time_left};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL ignore s=%0d c=%0d got %b/%b/%b/%0d want 0/0/0/0", s, c,
                             got.mag, got.cook, got.dn, got.tl);
                end
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef DONE_BEEP_EN
    task automatic test_beep();
        logic exp_b;
        door_closed = 1'b1; power_lvl = 4'd3; time_load = TIME_W'(1);
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            exp_b = (c >= 4) && (c < 16);
            n_checks++;
            if (beep !== exp_b || done !== (c >= 4)) begin
                n_fail++;
                $display("FAIL beep c=%0d got beep=%b done=%b want %b/%b", c, beep, done,
                         exp_b, (c >= 4));
            end
        end
        @(posedge clk); #1 stop_clear = 1'b1;
        @(posedge clk); #1 stop_clear = 1'b0;
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 6; c++) @(posedge clk);
        #1 stop_clear = 1'b1;
        @(posedge clk); #1 stop_clear = 1'b0;
        n_checks++;
        if (beep !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL beep_early_clear got beep=%b done=%b want 0/0", beep, done);
        end
    endtask
`endif

    task automatic test_reset_mid();
        door_closed = 1'b1; power_lvl = 4'd10; time_load = TIME_W'(9);
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_checks++;
        if (magnetron_on !== 1'b1 || cooking !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre got mag=%b cooking=%b want 1/1", magnetron_on, cooking);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({magnetron_on, cooking, done, time_left} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async got %b/%b/%b/%0d want 0/0/0/0",
                     magnetron_on, cooking, done, time_left);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if ({magnetron_on, cooking, done, time_left} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_after got %b/%b/%b/%0d want 0/0/0/0",
                     magnetron_on, cooking, done, time_left);
        end
    endtask

    initial begin
        test_reset();
        test_cook_basic();
        test_duty();
        test_door();
        test_stop();
        test_ignore();
`ifdef DONE_BEEP_EN
        test_beep();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
